// File: rtl/life_key_pkg.sv
// Shared constants for the life_key_cond input-conditioning slice: key indices,
// repeat FSM encoding and the accelerated repeat interval helper.
package life_key_pkg;

  localparam int NUM_KEYS  = 6;
  localparam int KEY_NXT   = 0;
  localparam int KEY_FLIP  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_LEFT  = 4;
  localparam int KEY_RIGHT = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Accelerated repeat interval: a quarter of the base rate, never below one cycle.
  function automatic int accel_rate(input int rate);
    return ((rate / 32'sd4) < 32'sd1) ? 32'sd1 : (rate / 32'sd4);
  endfunction

endpackage

// File: rtl/life_key_chan.sv
// One button channel: 2-flop synchronizer, debounce, press-edge pulse and, when
// REPEAT_EN is set, the auto-repeat FSM (accelerates under LIFE_KEY_ACCEL_EN).
module life_key_chan
  import life_key_pkg::*;
#(
  parameter int DEB_CYCLES   = 50000,
  parameter int REPEAT_DELAY = 12000000,
  parameter int REPEAT_RATE  = 3000000,
  parameter int CNT_W        = 24,
  parameter int BTN_ACT_LOW  = 0,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic key
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 32'sd1);

  logic [1:0]       sync_r;
  logic             st_r;
  logic [CNT_W-1:0] cnt_r;
  logic             lvl_s;
  logic             accept_s;
  logic             press_s;
  logic             key_r;

  // Polarity-corrected level and debounce terminal-count acceptance.
  always_comb begin
    lvl_s    = (BTN_ACT_LOW != 32'sd0) ? ~sync_r[1] : sync_r[1];
    accept_s = (lvl_s != st_r) && (cnt_r == DEB_LAST);
    press_s  = accept_s && lvl_s;
  end

  // Synchronizer and debounce counter; any edge with s == st restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b00;
      st_r   <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      sync_r <= {sync_r[0], btn};
      if (accept_s) begin
        st_r  <= lvl_s;
        cnt_r <= {CNT_W{1'b0}};
      end else if (lvl_s != st_r) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  generate
    if (REPEAT_EN != 32'sd0) begin : g_rep
      localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 32'sd1);
      localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 32'sd1);
`ifdef LIFE_KEY_ACCEL_EN
      localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(accel_rate(REPEAT_RATE) - 32'sd1);
      logic [2:0]       rep_cnt_r;
`endif
      rep_state_t       state_r;
      logic [CNT_W-1:0] rcnt_r;
      logic [CNT_W-1:0] rate_last_s;
      logic             fall_s;

      // Release detection and the current repeat interval terminal count.
      always_comb begin
        fall_s = accept_s && !lvl_s;
`ifdef LIFE_KEY_ACCEL_EN
        rate_last_s = (rep_cnt_r == 3'd7) ? ACC_LAST : RATE_LAST;
`else
        rate_last_s = RATE_LAST;
`endif
      end

      // Repeat FSM; release wins over a coinciding repeat pulse.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_r <= IDLE;
          rcnt_r  <= {CNT_W{1'b0}};
          key_r   <= 1'b0;
`ifdef LIFE_KEY_ACCEL_EN
          rep_cnt_r <= 3'd0;
`endif
        end else begin
          key_r  <= 1'b0;
          rcnt_r <= rcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (fall_s) begin
            state_r <= IDLE;
            rcnt_r  <= {CNT_W{1'b0}};
          end else begin
            case (state_r)
              IDLE: begin
                rcnt_r <= {CNT_W{1'b0}};
`ifdef LIFE_KEY_ACCEL_EN
                rep_cnt_r <= 3'd0;
`endif
                if (press_s) begin
                  key_r   <= 1'b1;
                  state_r <= DELAY;
                end
              end
              DELAY: begin
                if (rcnt_r == DLY_LAST) begin
                  key_r   <= 1'b1;
                  rcnt_r  <= {CNT_W{1'b0}};
                  state_r <= REPEAT;
                end
              end
              REPEAT: begin
                if (rcnt_r == rate_last_s) begin
                  key_r  <= 1'b1;
                  rcnt_r <= {CNT_W{1'b0}};
`ifdef LIFE_KEY_ACCEL_EN
                  if (rep_cnt_r != 3'd7) begin
                    rep_cnt_r <= rep_cnt_r + 3'd1;
                  end
`endif
                end
              end
              default: begin
                state_r <= IDLE;
                rcnt_r  <= {CNT_W{1'b0}};
              end
            endcase
          end
        end
      end
    end else begin : g_norep
      // Press pulse only; these keys never repeat.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          key_r <= 1'b0;
        end else begin
          key_r <= press_s;
        end
      end
    end
  endgenerate

  assign key = key_r;

endmodule

// File: rtl/life_key_cond.sv
// Conditions six raw buttons into single-cycle key pulses for the life core;
// arrows auto-repeat. Define LIFE_KEY_ACCEL_EN for accelerated repeat.
module life_key_cond
  import life_key_pkg::*;
#(
  parameter int DEB_CYCLES   = 50000,
  parameter int REPEAT_DELAY = 12000000,
  parameter int REPEAT_RATE  = 3000000,
  parameter int CNT_W        = 24,
  parameter int BTN_ACT_LOW  = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_nxt,
  input  logic btn_flip,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic key_nxt,
  output logic key_flip,
  output logic key_up,
  output logic key_down,
  output logic key_left,
  output logic key_right
);

  logic [NUM_KEYS-1:0] btn_s;
  logic [NUM_KEYS-1:0] key_s;

  assign btn_s[KEY_NXT]   = btn_nxt;
  assign btn_s[KEY_FLIP]  = btn_flip;
  assign btn_s[KEY_UP]    = btn_up;
  assign btn_s[KEY_DOWN]  = btn_down;
  assign btn_s[KEY_LEFT]  = btn_left;
  assign btn_s[KEY_RIGHT] = btn_right;

  // Channels are fully independent; only the arrow keys get the repeat FSM.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    life_key_chan #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_W       (CNT_W),
      .BTN_ACT_LOW (BTN_ACT_LOW),
      .REPEAT_EN   ((i >= KEY_UP) ? 32'sd1 : 32'sd0)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_s[i]),
      .key  (key_s[i])
    );
  end

  assign key_nxt   = key_s[KEY_NXT];
  assign key_flip  = key_s[KEY_FLIP];
  assign key_up    = key_s[KEY_UP];
  assign key_down  = key_s[KEY_DOWN];
  assign key_left  = key_s[KEY_LEFT];
  assign key_right = key_s[KEY_RIGHT];

endmodule

// File: tb/tb_life_key_cond.sv
// Scoreboard bench for life_key_cond: a per-edge reference model queues expected
// key pulses, a negedge monitor pops and compares; directed timing checks too.
module tb_life_key_cond;
  import life_key_pkg::*;

  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] btn_v;
  logic       key_nxt, key_flip, key_up, key_down, key_left, key_right;
  logic [5:0] key_v;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_cyc[$];
  logic [5:0] exp_vec[$];
  int watch_key = -1;
  int watch_q[$];

  int  hist1 [6];
  int  hist2 [6];
  int  st_m  [6];
  int  run_m [6];
  int  held_m[6];
  int  press_m[6];

  assign key_v = {key_right, key_left, key_down, key_up, key_flip, key_nxt};

  life_key_cond #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(8), .BTN_ACT_LOW(0)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_nxt(btn_v[KEY_NXT]), .btn_flip(btn_v[KEY_FLIP]), .btn_up(btn_v[KEY_UP]),
    .btn_down(btn_v[KEY_DOWN]), .btn_left(btn_v[KEY_LEFT]), .btn_right(btn_v[KEY_RIGHT]),
    .key_nxt(key_nxt), .key_flip(key_flip), .key_up(key_up),
    .key_down(key_down), .key_left(key_left), .key_right(key_right)
  );

  always #5 clk = ~clk;

  // Offset d edges after a press pulse: is it a repeat pulse instant?
  function automatic bit is_rep(input int d);
    int m;
    int q;
    if (d < DLY) return 1'b0;
    m = d - DLY;
`ifdef LIFE_KEY_ACCEL_EN
    q = (RATE / 4 < 1) ? 1 : RATE / 4;
    if (m > 7 * RATE) return ((m - 7 * RATE) % q) == 0;
`endif
    return (m % RATE) == 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: evaluated at each active edge with the pre-edge inputs.
  initial begin
    logic [5:0] vec;
    int s;
    bit acc;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        for (int k = 0; k < 6; k++) begin
          hist1[k] = 0; hist2[k] = 0; st_m[k] = 0; run_m[k] = 0; held_m[k] = 0;
        end
      end else begin
        vec = '0;
        for (int k = 0; k < 6; k++) begin
          s = hist2[k];
          hist2[k] = hist1[k];
          hist1[k] = int'(btn_v[k]);
          acc = 1'b0;
          if (s != st_m[k]) begin
            run_m[k]++;
            if (run_m[k] == DEB) begin
              acc = 1'b1;
              st_m[k] = s;
              run_m[k] = 0;
            end
          end else begin
            run_m[k] = 0;
          end
          if (acc && s == 1) begin
            vec[k] = 1'b1;
            held_m[k] = 1;
            press_m[k] = cyc;
          end else if (acc) begin
            held_m[k] = 0;
          end else if (held_m[k] == 1 && k >= KEY_UP && is_rep(cyc - press_m[k])) begin
            vec[k] = 1'b1;
          end
        end
        if (vec != 6'd0) begin
          exp_cyc.push_back(cyc);
          exp_vec.push_back(vec);
        end
      end
    end
  end

  // Monitor: compares DUT pulses against queued expectations on the falling edge.
  initial begin
    int ec;
    logic [5:0] ev;
    forever begin
      @(negedge clk);
      while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
        ec = exp_cyc.pop_front();
        ev = exp_vec.pop_front();
        checks++; errors++;
        $display("FAIL missed_pulse: edge %0d expected keys %b got nothing", ec, ev);
      end
      if (reset) begin
        chk("reset_outputs_zero", int'(key_v), 0);
      end else if (key_v != 6'd0) begin
        if (watch_key >= 0 && key_v[watch_key]) watch_q.push_back(cyc);
        if (exp_cyc.size() == 0 || exp_cyc[0] != cyc) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: edge %0d got keys %b expected none", cyc, key_v);
        end else begin
          ec = exp_cyc.pop_front();
          ev = exp_vec.pop_front();
          chk("pulse_vector", int'(key_v), int'(ev));
        end
      end
    end
  end

  initial begin
    int e0;
    int offs[6] = '{6, 26, 34, 42, 50, 58};
    reset = 1'b1;
    btn_v = 6'd0;
    tick(3);
    reset = 1'b0;
    chk("reset_state_keys", int'(key_v), 0);
    tick(2);

    // Clean flip press: one pulse at raw rise + DEB+2, none on release.
    watch_key = KEY_FLIP; watch_q.delete();
    e0 = cyc; btn_v[KEY_FLIP] = 1'b1;
    tick(100); btn_v[KEY_FLIP] = 1'b0; tick(20);
    chk("flip_count", watch_q.size(), 1);
    if (watch_q.size() > 0) chk("flip_latency", watch_q[0] - e0, DEB + 2);

    // Bouncing nxt: single pulse DEB+2 after the last toggle.
    watch_key = KEY_NXT; watch_q.delete();
    btn_v[KEY_NXT] = 1'b1; tick(1);
    btn_v[KEY_NXT] = 1'b0; tick(1);
    btn_v[KEY_NXT] = 1'b1; tick(1);
    btn_v[KEY_NXT] = 1'b0; tick(1);
    e0 = cyc; btn_v[KEY_NXT] = 1'b1;
    tick(40); btn_v[KEY_NXT] = 1'b0; tick(20);
    chk("nxt_bounce_count", watch_q.size(), 1);
    if (watch_q.size() > 0) chk("nxt_bounce_latency", watch_q[0] - e0, DEB + 2);

    // Right held 60 cycles: press plus repeat train, stops on release.
    watch_key = KEY_RIGHT; watch_q.delete();
    e0 = cyc; btn_v[KEY_RIGHT] = 1'b1;
    tick(60); btn_v[KEY_RIGHT] = 1'b0; tick(20);
    chk("right_count", watch_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < watch_q.size()) chk("right_pulse_time", watch_q[i] - e0, offs[i]);
    end

    // Up and left together: same-cycle pulses, checked as a vector.
    watch_key = KEY_UP; watch_q.delete();
    e0 = cyc; btn_v[KEY_UP] = 1'b1; btn_v[KEY_LEFT] = 1'b1;
    tick(10); btn_v[KEY_UP] = 1'b0; btn_v[KEY_LEFT] = 1'b0; tick(15);
    chk("up_left_count", watch_q.size(), 1);
    if (watch_q.size() > 0) chk("up_left_latency", watch_q[0] - e0, DEB + 2);

    // Down held, reset mid-DELAY, fresh press after release.
    watch_key = KEY_DOWN;
    btn_v[KEY_DOWN] = 1'b1;
    tick(16);
    reset = 1'b1; watch_q.delete();
    tick(3);
    reset = 1'b0; e0 = cyc;
    tick(40); btn_v[KEY_DOWN] = 1'b0; tick(20);
    chk("down_after_reset_count", watch_q.size(), 4);
    if (watch_q.size() > 1) begin
      chk("down_after_reset_press", watch_q[0] - e0, DEB + 2);
      chk("down_after_reset_repeat", watch_q[1] - e0, DEB + 2 + DLY);
    end

`ifdef LIFE_KEY_ACCEL_EN
    // Accelerated repeat: after the 8th repeat the interval drops to RATE/4.
    watch_key = KEY_LEFT; watch_q.delete();
    btn_v[KEY_LEFT] = 1'b1;
    tick(150); btn_v[KEY_LEFT] = 1'b0; tick(20);
    if (watch_q.size() > 10) begin
      chk("accel_before", watch_q[8] - watch_q[7], RATE);
      chk("accel_after", watch_q[9] - watch_q[8], RATE / 4);
    end else begin
      chk("accel_count", watch_q.size(), 11);
    end
`endif

    // Random phase: slow random toggling on all keys.
    watch_key = -1;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 15) == 0) btn_v[k] = ~btn_v[k];
      end
      tick(1);
    end
    btn_v = 6'd0;
    tick(40);
    chk("scoreboard_drained", exp_cyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_key_cond.md
Name: life_key_cond

Overview:
- Input-conditioning stage directly upstream of the life core; drives its key_nxt, key_flip, key_up, key_down, key_left and key_right inputs.
- Takes six raw, asynchronous, bouncing push-buttons and applies a per-key 2-flop synchronizer, a debounce counter and press-edge detection.
- Each key output is a clean single-cycle pulse per press.
- Arrow keys additionally auto-repeat while held, so the cursor can be slewed across the X by Y field.

Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles needed to accept a level change (>=1).
- REPEAT_DELAY, 12000000: cycles from the press pulse to the first repeat pulse (>=1).
- REPEAT_RATE, 3000000: cycles between subsequent repeat pulses (>=1).
- CNT_W, 24: width of the debounce and repeat counters; must hold max(DEB_CYCLES, REPEAT_DELAY, REPEAT_RATE)-1.
- BTN_ACT_LOW, 0: 1 means raw buttons are active-low; inverted after synchronization.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_nxt  in  1  raw next-generation button
- btn_flip  in  1  raw flip-cell button
- btn_up  in  1  raw cursor-up button
- btn_down  in  1  raw cursor-down button
- btn_left  in  1  raw cursor-left button
- btn_right  in  1  raw cursor-right button
- key_nxt  out  1  press pulse
- key_flip  out  1  press pulse
- key_up  out  1  press/repeat pulse
- key_down  out  1  press/repeat pulse
- key_left  out  1  press/repeat pulse
- key_right  out  1  press/repeat pulse

Behaviour:
- Reset (async, active-high): clears synchronizer flops, stable levels, counters, FSM state (IDLE) and all key_* outputs to 0. All outputs are registered.
- Synchronizer: two flops per button, then polarity correction per BTN_ACT_LOW. Synchronized level s is valid 2 edges after a raw change.
- Debounce, per key, with registered stable level st:
  - s != st: cnt increments each edge.
  - cnt == DEB_CYCLES-1 with s != st still true: st <= s, cnt <= 0.
  - s == st on any edge: cnt <= 0, so a glitch restarts the count.
- Press pulse: on the edge where st goes 0 to 1, the key output is high for exactly one cycle. Total latency from the raw level to the pulse is DEB_CYCLES+2 edges. Release never produces a pulse.
- Auto-repeat FSM (arrow keys only; key_nxt and key_flip never repeat). States IDLE, DELAY, REPEAT:
  - IDLE: on press pulse, go to DELAY with rcnt=0.
  - DELAY: rcnt counts. At rcnt==REPEAT_DELAY-1, emit 1-cycle pulse, rcnt<=0, go to REPEAT.
  - REPEAT: at rcnt==REPEAT_RATE-1, emit pulse, rcnt<=0.
  - Debounced release (st falls) in any state: IDLE next edge, rcnt<=0, no pulse that cycle.
- Keys are fully independent. Simultaneous presses pulse in the same cycle; there is no priority or masking.
- A key held through reset deassertion produces a press pulse DEB_CYCLES+2 edges after reset release, because st resets to 0.
- Reset mid-debounce or mid-repeat aborts immediately; no residual pulse.
- Counters never wrap: they are always cleared at their terminal count.

Optional Feature:
- LIFE_KEY_ACCEL_EN defined: in REPEAT, after 8 repeat pulses the interval becomes REPEAT_RATE/4 (minimum 1) until release. A 3-bit saturating repeat counter is cleared in IDLE.
- Undefined: fixed REPEAT_RATE interval; no repeat counter is present.

Decomposition:
- Package life_key_pkg:
  - NUM_KEYS=6.
  - Key index constants: KEY_NXT=0, KEY_FLIP=1, KEY_UP=2, KEY_DOWN=3, KEY_LEFT=4, KEY_RIGHT=5.
  - Repeat FSM state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2.
- Sub-module life_key_chan holds synchronizer, debounce, edge detect and repeat FSM. Parameter REPEAT_EN selects repeat; it is 1 for arrows and 0 for nxt/flip.
- The top instantiates six channels.

Test Plan (bench uses DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8):
- Clean press of btn_flip held 100 cycles -> key_flip high exactly once, 6 edges after the raw rise; no pulse on release.
- btn_nxt bouncing (1,0,1,0 toggles each cycle, then steady 1) -> a single key_nxt pulse, 6 edges after the last toggle.
- btn_right held 60 cycles -> pulses at press+6, +26, +34, +42, +50, +58 relative to the raw rise; all stop within DEB_CYCLES+2 edges of the raw release.
- btn_up and btn_left pressed on the same cycle -> key_up and key_left pulse on the same cycle; other outputs stay 0.
- btn_down held, reset asserted mid-DELAY for 3 cycles -> all outputs 0 immediately; fresh press pulse 6 edges after reset release, then the repeat sequence restarts.
- LIFE_KEY_ACCEL_EN defined, btn_left held 150 cycles -> after the 8th repeat pulse, interval drops from 8 to 2 cycles.
